mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 32, data word width, equal to the InstructionStruct DWIDTH.
REQ-002 The block SHALL have parameter AWIDTH, default 10, word address width, equal to the InstructionStruct AWIDTH.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 f_req  input  1  fetch-port read request, held high until f_ack.
REQ-006 f_addr  input  AWIDTH  fetch-port word address.
REQ-007 f_ack  output  1  fetch-port completion pulse, one cycle.
REQ-008 f_rdata  output  DWIDTH  fetch-port read data, valid while f_ack=1.
REQ-009 d_req  input  1  data-port request, held high until d_ack.
REQ-010 d_we  input  1  data-port op: 1 = write, 0 = read.
REQ-011 d_addr  input  AWIDTH  data-port word address.
REQ-012 d_wdata  input  DWIDTH  data-port write data.
REQ-013 d_ack  output  1  data-port completion pulse, one cycle.
REQ-014 d_rdata  output  DWIDTH  data-port read data, valid while d_ack=1.
REQ-015 mem_addr  output  AWIDTH  RAM address.
REQ-016 mem_rdEn  output  1  RAM read enable; the RAM drives mem_data while high.
REQ-017 mem_wrEn  output  1  RAM write enable; the RAM writes mem_data at posedge while high and mem_rdEn=0.
REQ-018 mem_data  inout  DWIDTH  shared tri-state RAM data bus.
REQ-019 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-020 The FSM SHALL have states IDLE, READ, WRITE and ACK.
REQ-021 In IDLE, with neither request high, the FSM SHALL remain in IDLE.
REQ-022 In IDLE, with exactly one request high, that port SHALL be granted.
REQ-023 In IDLE, with both requests high, the port not granted last SHALL be granted (round-robin over last_grant).
REQ-024 On grant, the block SHALL register the address, the op (fetch is always read), the write data and the grantee, then update last_grant.
REQ-025 After a grant the FSM SHALL move to WRITE for a data-port write and to READ otherwise.
REQ-026 READ SHALL last exactly one cycle: mem_rdEn=1, mem_wrEn=0, mem_addr=registered address, mem_data not driven by this block.
REQ-027 At the posedge ending READ, the block SHALL capture mem_data into the grantee's rdata register and go to ACK.
REQ-028 WRITE SHALL last exactly one cycle: mem_wrEn=1, mem_rdEn=0, mem_addr=registered address, mem_data driven with the registered write data.
REQ-029 After WRITE the FSM SHALL go to ACK; the RAM commits the write at that same posedge.
REQ-030 In ACK, the grantee's ack SHALL be 1 for one cycle; requests SHALL be ignored; the next state SHALL be IDLE.
REQ-031 Latency SHALL be 2 cycles from the req-sampling edge to ack high; sustained throughput SHALL be one transaction per 3 cycles.
REQ-032 A requester keeping req high through ACK SHALL be treated as requesting a new transaction when it is next sampled in IDLE.
REQ-033 The block SHALL drive mem_data only in WRITE and SHALL leave it high-Z in every other state.
REQ-034 mem_rdEn and mem_wrEn SHALL never be high in the same cycle.
REQ-035 f_rdata and d_rdata SHALL hold their last captured values between acks.
REQ-036 Port inputs SHALL be ignored outside IDLE; changes to them after grant SHALL NOT affect the transaction in flight.
REQ-037 All outputs except mem_data SHALL be registered or decoded from state only, with no combinational path from req inputs.

Reset
REQ-038 When reset=1 at a posedge, the block SHALL set: state=IDLE, last_grant=data (so fetch wins the first tie), f_ack=d_ack=0, f_rdata=d_rdata=0, mem_addr=0, mem_rdEn=mem_wrEn=0, busy=0, mem_data high-Z.
REQ-039 Reset in READ or WRITE SHALL abort the transaction with no ack.
REQ-040 A write whose WRITE cycle coincides with the reset edge SHALL still be committed by the RAM.
REQ-041 Reset in ACK SHALL suppress the pending ack from the following cycle.
REQ-042 Reset SHALL take priority over every request.

Verification
REQ-043 Fetch read: f_req=1, f_addr=5, with RAM[5]=0x0000_0005 -> mem_rdEn high in cycle 1, f_ack=1 in cycle 2 with f_rdata=0x0000_0005, d_ack stays 0.
REQ-044 Data write then read: d_we=1, d_addr=3, d_wdata=0xDEAD_BEEF -> mem_wrEn one cycle, d_ack; then d_we=0, d_addr=3 -> d_rdata=0xDEAD_BEEF.
REQ-045 Contention: both reqs high from reset for 4 transactions -> grant order fetch, data, fetch, data; one ack every 3 cycles; no cycle with both enables high.
REQ-046 Reset mid-READ: assert reset during READ -> no ack; next cycle state=IDLE, busy=0, mem_rdEn=0.
REQ-047 Bus hygiene: monitor every cycle -> mem_data driven by the block only when mem_wrEn=1; never X on mem_data while mem_rdEn=1 and addresses are within MEMDEPTH.
REQ-048 Input change after grant: change d_addr from 7 to 9 during WRITE -> RAM[7] updated and RAM[9] unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between fetch and data ports sharing one single-port RAM
// over a tri-state data bus; one transaction per 3 cycles (IDLE, READ/WRITE, ACK).
module mem_arbiter #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [AWIDTH-1:0] f_addr,
  output logic              f_ack,
  output logic [DWIDTH-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [AWIDTH-1:0] d_addr,
  input  logic [DWIDTH-1:0] d_wdata,
  output logic              d_ack,
  output logic [DWIDTH-1:0] d_rdata,
  output logic [AWIDTH-1:0] mem_addr,
  output logic              mem_rdEn,
  output logic              mem_wrEn,
  inout  wire  [DWIDTH-1:0] mem_data,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, ACK} state_t;

  state_t            state, state_nxt;
  logic              last_data;
  logic              gnt_data;
  logic              take;
  logic              grant_data;
  logic              drive_bus;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] wdata_q;

  // On a tie the port that did not win last time gets the grant.
  always_comb begin
    take       = (state == IDLE) && (f_req || d_req);
    grant_data = d_req && (!f_req || !last_data);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = (grant_data && d_we) ? WRITE : READ;
      READ:    state_nxt = ACK;
      WRITE:   state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_rdEn  = (state == READ);
    mem_wrEn  = (state == WRITE);
    drive_bus = (state == WRITE);
    busy      = (state != IDLE);
    f_ack     = (state == ACK) && !gnt_data;
    d_ack     = (state == ACK) && gnt_data;
    mem_addr  = addr_q;
  end

  assign mem_data = drive_bus ? wdata_q : {DWIDTH{1'bz}};

  // Request fields are captured only at grant, so later input changes cannot disturb the access.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_data <= 1'b1;
      gnt_data  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      f_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      if (take) begin
        gnt_data  <= grant_data;
        last_data <= grant_data;
        addr_q    <= grant_data ? d_addr : f_addr;
        wdata_q   <= d_wdata;
      end
      if (state == READ) begin
        if (gnt_data) d_rdata <= mem_data;
        else          f_rdata <= mem_data;
      end
    end
  end

endmodule
